arduino_rx_port: RTL and testbench
==================================

// Module: arduino_rx_port
// PURPOSE
// - Inbound half of the Arduino link: host drives 16-bit words into the processor.
//   The outbound half is procesadorArm -> dataArduino, qualified by clkArduino/readEnable.
// - Host strobe and data are asynchronous to clk. The block synchronizes them,
//   detects the host strobe edge, captures the word and pushes it into a FIFO.
// - The processor's load path pops words through a simple read port.
//   Status bits are exposed for memory-mapped polling.
// PARAMETERS
// - DATA_W   16  width of host data word
// - DEPTH    8   FIFO entries; power of two, >= 2
// - SYNC_FF  2   synchronizer stages on ext_clk/ext_we; >= 2
// PORTS
// - clk          in   1                system clock
// - rst          in   1                asynchronous reset, active-high
// - ext_clk      in   1                host strobe; async; word taken on its rising edge
// - ext_we       in   1                host write-enable; async; qualifies the strobe
// - ext_data     in   DATA_W           host word; stable >= SYNC_FF+2 clk around edge
// - cpu_rd_en    in   1                pop request from processor
// - cpu_clr      in   1                synchronous flush of FIFO and sticky flags
// - cpu_rd_data  out  DATA_W           popped word
// - cpu_rd_valid out  1                cpu_rd_data valid this cycle
// - empty        out  1                FIFO empty
// - full         out  1                FIFO full
// - count        out  $clog2(DEPTH)+1  occupancy
// - overflow     out  1                sticky: word dropped while full
// BEHAVIOUR
// - Reset (async, rst=1): all outputs 0 except empty=1. Pointers, synchronizers
//   and FSM cleared; FSM=IDLE. Reset mid-transfer discards the in-flight word.
// - Synchronizers: ext_clk/ext_we pass SYNC_FF flops; ext_data registered at capture.
// - FSM (arduino_pkg::rx_state_t):
//   - IDLE: on synced ext_clk 0->1 with synced ext_we=1 -> CAPTURE.
//     ext_clk rising with ext_we=0 -> HOLD, nothing captured.
//   - CAPTURE: one cycle. Push ext_data if !full, else set overflow. -> HOLD.
//   - HOLD: wait for synced ext_clk=0 -> IDLE. Guarantees one push per host edge.
// - Capture latency: push visible (count/empty) SYNC_FF+2 clk after ext_clk rises.
// - Pop: cpu_rd_en && !empty -> cpu_rd_data/cpu_rd_valid registered next cycle
//   (1-cycle latency). cpu_rd_valid is a single-cycle pulse per pop.
//   Pop when empty: ignored, cpu_rd_valid=0, cpu_rd_data holds its last value.
// - Simultaneous push and pop:
//   - Not full: both occur, count unchanged.
//   - Full: pop frees a slot and the push is accepted; no overflow.
// - Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//   full = MSBs differ and LSBs equal; empty = pointers equal.
// - cpu_clr: next cycle pointers=0, count=0, overflow=0, cpu_rd_valid=0.
//   A concurrent push or pop is discarded. The FSM keeps its state, so no spurious capture.
// - overflow stays set until rst or cpu_clr.
// STRUCTURE
// - arduino_pkg:
//   - ARDUINO_DATA_W=16
//   - typedef enum logic[1:0] {RX_IDLE, RX_CAPTURE, RX_HOLD} rx_state_t
//   - shared with the transmit side
// - Sub-module arduino_sync_fifo(DATA_W, DEPTH): push/pop/clr, full/empty/count, registered read.
// - Top: synchronizers, edge detect, FSM, overflow flag, FIFO instance.
// TESTING
// - T1: rst pulse mid-HOLD -> empty=1, count=0, overflow=0, FSM=IDLE;
//   the next host edge is captured normally.
// - T2: host writes 0x1234, 0xBEEF, then 3 pops
//   -> cpu_rd_data 0x1234, 0xBEEF, one cycle after each rd_en;
//   third pop gives cpu_rd_valid=0 and data unchanged.
// - T3: 9 writes with DEPTH=8, no pops -> full=1, count=8, overflow=1;
//   8 pops return words 1..8 in order.
// - T4: ext_clk held high 20 clk with ext_we=1 -> exactly one push.
//   ext_clk rising with ext_we=0 -> no push.
// - T5: FIFO full, push and pop in the same cycle -> count stays 8, overflow=0, order preserved.
// - T6: 3 words queued, cpu_clr -> count=0, empty=1, overflow=0;
//   20 push/pop cycles exercise pointer wrap with data intact.

Source files
------------

// File: rtl/arduino_pkg.sv
// Shared definitions for the Arduino link: word width and receive FSM states.
package arduino_pkg;

  localparam int ARDUINO_DATA_W = 16;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_CAPTURE = 2'd1,
    RX_HOLD    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/arduino_sync_fifo.sv
// Single-clock FIFO with registered read port, synchronous flush and
// extra-MSB pointers for full/empty discrimination.
module arduino_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     clr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop_ok  = pop && !empty && !clr;
  assign push_ok = push && !clr && (!full || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
        rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/arduino_rx_port.sv
// Inbound Arduino link: synchronizes the host strobe, captures one word per
// rising strobe edge into a FIFO and exposes a pop port plus status bits.
module arduino_rx_port
  import arduino_pkg::*;
#(
  parameter int DATA_W  = ARDUINO_DATA_W,
  parameter int DEPTH   = 8,
  parameter int SYNC_FF = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_clk,
  input  logic                   ext_we,
  input  logic [DATA_W-1:0]      ext_data,
  input  logic                   cpu_rd_en,
  input  logic                   cpu_clr,
  output logic [DATA_W-1:0]      cpu_rd_data,
  output logic                   cpu_rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  logic [SYNC_FF-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_FF-1:0] we_sync_q, we_sync_d;
  logic               clk_prev_q, clk_prev_d;
  rx_state_t          state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               overflow_q, overflow_d;
  logic               clk_s, we_s, clk_rise;
  logic               push;

  assign clk_s    = clk_sync_q[SYNC_FF-1];
  assign we_s     = we_sync_q[SYNC_FF-1];
  assign clk_rise = clk_s && !clk_prev_q;
  assign push     = (state_q == RX_CAPTURE);

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_FF-2:0], ext_clk};
    we_sync_d  = {we_sync_q[SYNC_FF-2:0], ext_we};
    clk_prev_d = clk_s;
  end

  // ext_data is sampled on the detected edge; the host keeps it stable long
  // enough that the synchronized strobe still sees a settled word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      RX_IDLE: begin
        if (clk_rise) begin
          if (we_s) begin
            state_d = RX_CAPTURE;
            data_d  = ext_data;
          end else begin
            state_d = RX_HOLD;
          end
        end
      end
      RX_CAPTURE: state_d = RX_HOLD;
      RX_HOLD:    if (!clk_s) state_d = RX_IDLE;
      default:    state_d = RX_IDLE;
    endcase
  end

  // A full FIFO only drops the word if no pop makes room in the same cycle.
  always_comb begin
    if (cpu_clr) overflow_d = 1'b0;
    else         overflow_d = overflow_q || (push && full && !cpu_rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '0;
      we_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      state_q    <= RX_IDLE;
      overflow_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      we_sync_q  <= we_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  arduino_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_q),
    .pop       (cpu_rd_en),
    .clr       (cpu_clr),
    .rd_data   (cpu_rd_data),
    .rd_valid  (cpu_rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_arduino_rx_port.sv
// Bench for arduino_rx_port: table of host/cpu operations with a data
// scoreboard, plus hand-written sequences for reset, long strobes and full-FIFO cases.
module tb_arduino_rx_port;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int SYNC_FF = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ext_clk, ext_we;
  logic [DATA_W-1:0] ext_data;
  logic              cpu_rd_en, cpu_clr;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_rd_valid, empty, full, overflow;
  logic [3:0]        count;

  arduino_rx_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_FF(SYNC_FF)) dut (
    .clk          (clk),
    .rst          (rst),
    .ext_clk      (ext_clk),
    .ext_we       (ext_we),
    .ext_data     (ext_data),
    .cpu_rd_en    (cpu_rd_en),
    .cpu_clr      (cpu_clr),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef enum {OP_WR, OP_WRN, OP_POP, OP_CLR} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] d;
    int          cnt;
    bit          ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] last_data;
  bit          m_ovf;
  int          n_vec;
  int          n_miss;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input op_e op, input logic [15:0] d, input int cnt, input bit ovf);
    vec_t v;
    v.op = op; v.d = d; v.cnt = cnt; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic host_write(input logic [15:0] d, input logic we, input int hi);
    @(posedge clk); #1;
    ext_data = d; ext_we = we; ext_clk = 1'b1;
    repeat (hi) @(posedge clk);
    #1 ext_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 ext_we = 1'b0;
    if (we) begin
      if (sb.size() < DEPTH) sb.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic cpu_pop();
    logic [15:0] e;
    @(posedge clk); #1 cpu_rd_en = 1'b1;
    @(posedge clk); #1 cpu_rd_en = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pop_valid", cpu_rd_valid, 1);
      chk("pop_data", cpu_rd_data, e);
      last_data = e;
    end else begin
      chk("empty_pop_valid", cpu_rd_valid, 0);
      chk("empty_pop_data_hold", cpu_rd_data, last_data);
    end
  endtask

  task automatic cpu_clear();
    @(posedge clk); #1 cpu_clr = 1'b1;
    @(posedge clk); #1 cpu_clr = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
  endtask

  task automatic chk_status(input string nm, input int cnt, input bit ovf);
    chk({nm, "_count"}, count, cnt);
    chk({nm, "_empty"}, empty, (cnt == 0));
    chk({nm, "_full"}, full, (cnt == DEPTH));
    chk({nm, "_overflow"}, overflow, ovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    n_vec = 0; n_miss = 0; m_ovf = 1'b0; last_data = '0;
    rst = 1'b1; ext_clk = 1'b0; ext_we = 1'b0; ext_data = '0;
    cpu_rd_en = 1'b0; cpu_clr = 1'b0;

    // T2: two words, three pops, the last on an empty FIFO
    add(OP_WR,  16'h1234, 1, 0);
    add(OP_WR,  16'hBEEF, 2, 0);
    add(OP_WRN, 16'h7777, 2, 0);
    add(OP_POP, 16'h0000, 1, 0);
    add(OP_POP, 16'h0000, 0, 0);
    add(OP_POP, 16'h0000, 0, 0);
    // T3: nine writes into eight slots, then drain, then flush clears overflow
    for (int i = 1; i <= 9; i++) add(OP_WR, 16'(i), (i > 8) ? 8 : i, (i == 9));
    for (int i = 1; i <= 8; i++) add(OP_POP, 16'h0000, 8 - i, 1);
    add(OP_CLR, 16'h0000, 0, 0);
    // T6: flush with words queued, then 20 push/pop pairs across pointer wrap
    for (int i = 1; i <= 3; i++) add(OP_WR, 16'h0A00 + 16'(i), i, 0);
    add(OP_CLR, 16'h0000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      add(OP_WR,  16'h6000 + 16'(i * 3), 1, 0);
      add(OP_POP, 16'h0000, 0, 0);
    end

    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_valid", cpu_rd_valid, 0);
    chk("rst_rd_data", cpu_rd_data, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[k]) begin
      case (vecs[k].op)
        OP_WR:   host_write(vecs[k].d, 1'b1, 6);
        OP_WRN:  host_write(vecs[k].d, 1'b0, 6);
        OP_POP:  cpu_pop();
        default: begin
          cpu_clear();
          chk("clr_rd_valid", cpu_rd_valid, 0);
        end
      endcase
      chk("vec_count", count, vecs[k].cnt);
      chk("vec_empty", empty, (vecs[k].cnt == 0));
      chk("vec_full", full, (vecs[k].cnt == DEPTH));
      chk("vec_overflow", overflow, vecs[k].ovf);
    end

    // T5: full FIFO, pop lands in the push cycle -> no overflow, order kept
    for (int i = 0; i < DEPTH; i++) host_write(16'h5000 + 16'(i), 1'b1, 6);
    chk_status("t5_fill", DEPTH, 0);
    @(posedge clk); #1;
    ext_data = 16'h5F00; ext_we = 1'b1; ext_clk = 1'b1;
    repeat (SYNC_FF + 1) @(posedge clk);
    #1 cpu_rd_en = 1'b1;
    @(posedge clk); #1 cpu_rd_en = 1'b0;
    e = sb.pop_front();
    chk("t5_pop_valid", cpu_rd_valid, 1);
    chk("t5_pop_data", cpu_rd_data, e);
    last_data = e;
    sb.push_back(16'h5F00);
    repeat (2) @(posedge clk);
    #1 ext_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 ext_we = 1'b0;
    chk_status("t5_same_cycle", DEPTH, 0);
    host_write(16'h5F01, 1'b1, 6);
    chk_status("t5_overflow", DEPTH, m_ovf);
    for (int i = 0; i < DEPTH; i++) cpu_pop();
    chk_status("t5_drained", 0, 1);

    // T1: reset while the FSM sits in HOLD after a capture
    @(posedge clk); #1;
    ext_data = 16'hDEAD; ext_we = 1'b1; ext_clk = 1'b1;
    repeat (SYNC_FF + 3) @(posedge clk);
    #1 chk("t1_pre_count", count, 1);
    rst = 1'b1;
    #1;
    chk_status("t1_reset", 0, 0);
    chk("t1_rd_valid", cpu_rd_valid, 0);
    chk("t1_rd_data", cpu_rd_data, 0);
    ext_clk = 1'b0; ext_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); m_ovf = 1'b0; last_data = '0;
    host_write(16'h5A5A, 1'b1, 6);
    chk_status("t1_after", 1, 0);
    cpu_pop();

    // T4: strobe held high 20 cycles gives one push, at SYNC_FF+2 latency
    @(posedge clk); #1;
    ext_data = 16'hC0DE; ext_we = 1'b1; ext_clk = 1'b1;
    repeat (SYNC_FF + 1) @(posedge clk);
    #1 chk("t4_latency_before", count, 0);
    @(posedge clk);
    #1 chk("t4_latency_at", count, 1);
    repeat (20 - SYNC_FF - 2) @(posedge clk);
    #1 ext_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 ext_we = 1'b0;
    sb.push_back(16'hC0DE);
    chk_status("t4_long_strobe", 1, 0);
    host_write(16'h0BAD, 1'b0, 6);
    chk_status("t4_we_low", 1, 0);
    host_write(16'h1111, 1'b1, 6);
    chk_status("t4_next", 2, 0);
    cpu_pop();
    cpu_pop();
    cpu_pop();
    chk_status("t4_end", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
